// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit bridging a single-issue request port to a
// word-addressed bus with byte lane masks.
// Flow: IDLE accepts one request. An aligned request goes to BUS, which
// holds the access until the bus acks it. RESP then reports the result
// for exactly one cycle and returns to IDLE.
// A misaligned request skips the bus and goes straight to RESP with an
// address exception.
// Optional feature: define MEM_LSU_BUS_TIMEOUT_EN to abort a bus access
// that has not been acked after TIMEOUT_CYCLES cycles. The aborted access
// completes with a bus error.
module mem_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_sext_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_wreg_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_mask_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic [4:0]        resp_wreg_o,
  output logic              resp_wreg_we_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic              exc_buserr_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              stall_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t state, state_nx;

  // Request fields kept for the whole transaction
  logic              load_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        wreg_q;

  // Registered bus-side drive
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_mask_q;
  logic [31:0]       bus_wdata_q;

  // Completion status presented during RESP
  logic [31:0]       rdata_q;
  logic              adel_q;
  logic              ades_q;
  logic              buserr_q;

  logic accept;
  logic misal;
  logic ack_done;
  logic timeout_hit;

  // A half must be 2-byte aligned and a word 4-byte aligned. The reserved
  // size never has a legal alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate narrow store data across the word. Whichever lanes the mask
  // enables then carry the right bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the bus word, then zero- or sign-extend
  // it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sext);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   r = sext ? 32'(b) : {24'd0, b};
      2'b01:   r = sext ? 32'(h) : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept   = req_valid_i && (state == S_IDLE);
  assign misal    = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign ack_done = (state == S_BUS) && bus_ack_i;

`ifdef MEM_LSU_BUS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;

  // An ack on the same edge as expiry takes priority over the timeout.
  assign timeout_hit = (state == S_BUS) && !bus_ack_i && (to_cnt == TO_LAST);

  // Count bus-wait cycles. The count restarts with every accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if ((state == S_BUS) && !bus_ack_i && !timeout_hit) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = misal ? S_RESP : S_BUS;
      S_BUS:  if (ack_done || timeout_hit) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Transaction registers: latch the request, drive the bus, capture the result
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q      <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wreg_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_mask_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      buserr_q    <= 1'b0;
    end else if (accept) begin
      load_q   <= !req_we_i;
      size_q   <= req_size_i;
      sext_q   <= req_sext_i;
      addr_q   <= req_addr_i;
      wreg_q   <= req_wreg_i;
      rdata_q  <= '0;
      adel_q   <= misal && !req_we_i;
      ades_q   <= misal && req_we_i;
      buserr_q <= 1'b0;
      if (misal) begin
        bus_req_q   <= 1'b0;
        bus_we_q    <= 1'b0;
        bus_addr_q  <= '0;
        bus_mask_q  <= '0;
        bus_wdata_q <= '0;
      end else begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= req_we_i;
        bus_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
        bus_mask_q  <= lane_mask(req_size_i, req_addr_i[1:0]);
        bus_wdata_q <= req_we_i ? store_data(req_size_i, req_wdata_i) : 32'd0;
      end
    end else if (ack_done || timeout_hit) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_mask_q  <= '0;
      bus_wdata_q <= '0;
      if (ack_done) begin
        rdata_q <= load_q ? load_extract(bus_rdata_i, size_q, addr_q[1:0], sext_q) : 32'd0;
      end else begin
        buserr_q <= 1'b1;
      end
    end
  end

  // Output decode: response and exception signals are visible only in RESP
  always_comb begin
    req_ready_o    = (state == S_IDLE);
    stall_o        = (state != S_IDLE);
    bus_req_o      = bus_req_q;
    bus_we_o       = bus_we_q;
    bus_addr_o     = bus_addr_q;
    bus_mask_o     = bus_mask_q;
    bus_wdata_o    = bus_wdata_q;
    resp_valid_o   = 1'b0;
    resp_rdata_o   = '0;
    resp_wreg_o    = '0;
    resp_wreg_we_o = 1'b0;
    exc_adel_o     = 1'b0;
    exc_ades_o     = 1'b0;
    exc_buserr_o   = 1'b0;
    bad_addr_o     = '0;
    if (state == S_RESP) begin
      resp_valid_o   = 1'b1;
      resp_rdata_o   = rdata_q;
      resp_wreg_o    = wreg_q;
      resp_wreg_we_o = load_q && !(adel_q || ades_q || buserr_q);
      exc_adel_o     = adel_q;
      exc_ades_o     = ades_q;
      exc_buserr_o   = buserr_q;
      if (adel_q || ades_q || buserr_q) bad_addr_o = addr_q;
    end
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, address width of request and bus address.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, bus-wait cycles before bus error; range 1..65535.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid_i  in  1; req_ready_o  out  1: request handshake, transfer when both high.
REQ-006 req_we_i  in  1  1=store, 0=load.
REQ-007 req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_sext_i  in  1  sign-extend load result.
REQ-009 req_addr_i  in  ADDR_W; req_wdata_i  in  32; req_wreg_i  in  5 destination register.
REQ-010 bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  ADDR_W, word-aligned (bits[1:0]=0); bus_mask_o  out  4; bus_wdata_o  out  32.
REQ-011 bus_rdata_i  in  32; bus_ack_i  in  1  completes the outstanding bus access.
REQ-012 resp_valid_o  out  1  one-cycle completion pulse; resp_rdata_o  out  32; resp_wreg_o  out  5; resp_wreg_we_o  out  1.
REQ-013 exc_adel_o, exc_ades_o, exc_buserr_o  out  1 each; bad_addr_o  out  ADDR_W.
REQ-014 stall_o  out  1  high whenever state is not IDLE.

Function
REQ-015 States IDLE, BUS, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-016 IDLE + accepted aligned request -> BUS; bus_* outputs SHALL be registered and valid from the first BUS cycle.
REQ-017 Alignment: half requires addr[0]=0, word requires addr[1:0]=0, size 11 always misaligned.
REQ-018 Misaligned accept -> RESP without asserting bus_req_o; exc_adel_o (load) or exc_ades_o (store) high with resp_valid_o, bad_addr_o = request address.
REQ-019 Mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-020 Store data: byte replicated x4, half replicated x2, word as-is.
REQ-021 BUS: bus_req_o held high with constant address/mask/data until bus_ack_i sampled high; bus_rdata_i captured on that edge; next state RESP.
REQ-022 Load result: selected lane by addr[1:0] and size, zero- or sign-extended per req_sext_i to 32 bits.
REQ-023 RESP: resp_valid_o high exactly one cycle, then IDLE; earliest new accept the cycle after RESP.
REQ-024 resp_wreg_we_o = load & no exception; stores and faulted accesses SHALL NOT write registers.
REQ-025 Latency aligned access: accept edge N, bus_req_o high N+1, ack at edge M, resp_valid_o high cycle after M; minimum 3 cycles accept-to-response.
REQ-026 bus_ack_i outside BUS SHALL be ignored.
REQ-027 Outputs other than resp_* and exc_* SHALL be zero when not meaningful; exc_* and bad_addr_o zero except in RESP.

Reset
REQ-028 rst high: state IDLE, all outputs 0 except req_ready_o=1, next cycle.
REQ-029 rst during BUS SHALL drop bus_req_o at the next edge, discard the access, no resp_valid_o.
REQ-030 Timeout counter and captured data SHALL clear on reset.

Configuration
REQ-031 Macro MEM_LSU_BUS_TIMEOUT_EN defined: counter increments each BUS cycle without ack; reaching TIMEOUT_CYCLES -> RESP with exc_buserr_o=1, bad_addr_o=request address, bus_req_o dropped, no register write.
REQ-032 Macro undefined: no counter, exc_buserr_o tied 0, BUS waits indefinitely for bus_ack_i.
REQ-033 Ack and timeout on the same edge: ack SHALL win, normal completion.

Verification
REQ-034 LB addr 0x8000_0003, sext=1, bus_rdata 0x80FF_FF00, ack after 2 cycles -> mask 1000, resp_rdata 0xFFFF_FF80, wreg_we=1.
REQ-035 SH addr 0x1002, wdata 0x0000_BEEF, immediate ack -> bus_wdata 0xBEEF_BEEF, mask 1100, bus_addr 0x1000, wreg_we=0.
REQ-036 LW addr 0x1006 -> no bus_req_o, exc_adel_o=1, bad_addr_o 0x1006, resp 2 cycles after accept.
REQ-037 With MEM_LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> exc_buserr_o=1 after 4 BUS cycles; without macro stall_o stays 1 for 100 cycles.
REQ-038 rst asserted second BUS cycle of SW -> bus_req_o 0 next cycle, no resp_valid_o, req_ready_o 1.
REQ-039 Back-to-back LHU 0x2000 then LHU 0x2002, rdata 0x1234_ABCD -> results 0x0000_ABCD, 0x0000_1234, second accepted the cycle after first RESP.
